i2s_capture: RTL

I2S_CAPTURE -- requirements
Module: i2s_capture

---
 rtl/i2s_pkg.sv | 17 +
 rtl/i2s_capture_fifo.sv | 81 ++++++++
 rtl/i2s_capture.sv | 120 ++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared types for the I2S capture block: default word width, channel
// encoding and the {left, right} frame layout.
package i2s_pkg;

  localparam int DATA_W_DEF = 16;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } chan_e;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] left;
    logic [DATA_W_DEF-1:0] right;
  } frame_t;

endpackage

// File: rtl/i2s_capture_fifo.sv
// Output buffer for captured frames: a DEPTH-entry FIFO, or a single holding
// register when DEPTH is 1. Owns the sticky overrun flag.
module i2s_capture_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  input  logic             ready,
  input  logic             ovr_clr,
  output logic             overrun
);

  // valid/ready: a frame moves in every cycle where valid and ready are both
  // high; data is held stable while valid is high and ready is low.
  logic pop;
  logic full;

  assign pop = valid & ready;

  generate
    if (DEPTH == 1) begin : g_reg
      assign full = valid;

      always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
          data  <= '0;
          valid <= 1'b0;
        end else if (push && (!valid || pop)) begin
          data  <= push_data;
          valid <= 1'b1;
        end else if (pop) begin
          valid <= 1'b0;
        end
      end
    end else begin : g_fifo
      localparam int AW = $clog2(DEPTH);

      logic [WIDTH-1:0] mem [DEPTH];
      logic [AW-1:0]    wr_ptr;
      logic [AW-1:0]    rd_ptr;
      logic [AW:0]      count;
      logic             wr_en;

      assign full  = (count == (AW+1)'(DEPTH));
      // A pop frees the slot in the same cycle, so a full FIFO still accepts.
      assign wr_en = push && (!full || pop);
      assign data  = mem[rd_ptr];
      assign valid = (count != '0);

      always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
          for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
          wr_ptr <= '0;
          rd_ptr <= '0;
          count  <= '0;
        end else begin
          if (wr_en) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
          end
          if (pop) rd_ptr <= rd_ptr + 1'b1;
          if (wr_en && !pop)      count <= count + 1'b1;
          else if (!wr_en && pop) count <= count - 1'b1;
        end
      end
    end
  endgenerate

  // A drop outranks a simultaneous clear.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)                 overrun <= 1'b0;
    else if (push && full && !pop) overrun <= 1'b1;
    else if (ovr_clr)              overrun <= 1'b0;
  end

endmodule

// File: rtl/i2s_capture.sv
// Philips I2S receiver: synchronises bclk/lrclk/sd into clk, assembles
// {left, right} frames and buffers them. Define I2S_CAPTURE_FIFO_EN for a
// FIFO_DEPTH-entry output FIFO; otherwise a single holding register is used.
module i2s_capture
  import i2s_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic                i2s_bclk,
  input  logic                i2s_lrclk,
  input  logic                i2s_sd,
  output logic [2*DATA_W-1:0] sample_data,
  output logic                sample_valid,
  input  logic                sample_ready,
  input  logic                ovr_clr,
  output logic                overrun,
  output logic                frame_err
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
`ifdef I2S_CAPTURE_FIFO_EN
  localparam int BUF_DEPTH = FIFO_DEPTH;
`else
  localparam int BUF_DEPTH = 1;
`endif

  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic                bclk_s, lr_s, sd_s;
  logic                bclk_q;
  logic                rise, close, start;
  chan_e               lr_prev, cur_chan, bit_chan;
  logic [CNT_W-1:0]    bit_cnt;
  logic [DATA_W-1:0]   shreg, msb_bit;
  logic                word_ok;
  logic [DATA_W-1:0]   held_left;
  logic                held_valid;
  logic                push_q;
  logic [2*DATA_W-1:0] push_data;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], {i2s_bclk, i2s_lrclk, i2s_sd}};
  end

  assign bclk_s   = sync_q[SYNC_STAGES-1][2];
  assign lr_s     = sync_q[SYNC_STAGES-1][1];
  assign sd_s     = sync_q[SYNC_STAGES-1][0];
  assign rise     = bclk_s & ~bclk_q;
  // Philips delay: this bit belongs to the channel seen one rise earlier.
  assign bit_chan = lr_prev;
  assign close    = rise && (bit_cnt != '0) && (bit_chan != cur_chan);
  assign start    = close || (bit_cnt == '0);
  assign msb_bit  = {sd_s, {(DATA_W-1){1'b0}}};
  // The first close after reset ends a word of unknown start, so it is
  // dropped silently rather than flagged.
  assign frame_err = close && word_ok && (bit_cnt != CNT_W'(DATA_W));

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      bclk_q     <= 1'b0;
      lr_prev    <= LEFT;
      cur_chan   <= LEFT;
      bit_cnt    <= '0;
      shreg      <= '0;
      word_ok    <= 1'b0;
      held_left  <= '0;
      held_valid <= 1'b0;
      push_q     <= 1'b0;
      push_data  <= '0;
    end else begin
      bclk_q <= bclk_s;
      push_q <= 1'b0;
      if (rise) begin
        lr_prev  <= chan_e'(lr_s);
        cur_chan <= bit_chan;
        if (start) begin
          shreg   <= msb_bit;
          bit_cnt <= CNT_W'(1);
        end else begin
          // Bits beyond DATA_W shift out of range and are dropped.
          shreg <= shreg | (msb_bit >> bit_cnt);
          if (bit_cnt != '1) bit_cnt <= bit_cnt + 1'b1;
        end
        if (close) begin
          word_ok <= 1'b1;
          if (word_ok) begin
            if (cur_chan == LEFT) begin
              held_left  <= shreg;
              held_valid <= 1'b1;
            end else if (held_valid) begin
              push_q     <= 1'b1;
              push_data  <= {held_left, shreg};
              held_valid <= 1'b0;
            end
          end
        end
      end
    end
  end

  i2s_capture_fifo #(
    .WIDTH(2*DATA_W),
    .DEPTH(BUF_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .n_reset  (n_reset),
    .push     (push_q),
    .push_data(push_data),
    .data     (sample_data),
    .valid    (sample_valid),
    .ready    (sample_ready),
    .ovr_clr  (ovr_clr),
    .overrun  (overrun)
  );

endmodule
